prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter START_ADDR, default 12'h000, instruction-memory word address of the first loaded instruction.
REQ-002 Parameter MAX_WORDS, default 4096, instruction-memory depth; the length field must not exceed it.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_req  input  1  restarts a load from DONE or ERR.
REQ-006 in_data  input  8  byte stream, big-endian.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts a byte; a byte transfers when in_valid and in_ready are both 1.
REQ-009 im_wr_en  output  1  instruction-memory write strobe.
REQ-010 im_wr_addr  output  12  instruction-memory word address.
REQ-011 im_wr_data  output  19  instruction word to write.
REQ-012 cpu_start  output  1  one-cycle pulse releasing the CPU.
REQ-013 busy  output  1  high in any receiving state.
REQ-014 error  output  1  high while in ERR.

Function
REQ-015 Frame format: LEN_HI, LEN_LO, then N x {B0, B1, B2}.
- N = {LEN_HI[3:0], LEN_LO}; LEN_HI[7:4] is ignored.
- Instruction word = {B0[2:0], B1, B2}; B0[7:3] is ignored.
REQ-016 FSM states and transitions:
- LEN_HI -> LEN_LO on transfer.
- LEN_LO -> B0 on transfer if N != 0; otherwise to CHK (checksum enabled) or DONE.
- B0 -> B1 -> B2 on transfers.
- B2 -> B0 on transfer if words remain; otherwise to CHK or DONE.
- CHK -> DONE or ERR on transfer.
- DONE or ERR -> LEN_HI when load_req = 1.
REQ-017 in_ready = 1 in LEN_HI, LEN_LO, B0, B1, B2 and CHK; in_ready = 0 in DONE and ERR.
REQ-018 Write timing:
- im_wr_en is registered and is 1 for exactly one cycle, the cycle after the B2 transfer.
- im_wr_addr and im_wr_data are valid in that same cycle.
REQ-019 Addressing:
- The first word is written to START_ADDR; the address increments by 1 per word.
- The address wraps modulo 4096.
REQ-020 The word counter is 12 bits and loads N at LEN_LO; a load finishes when it reaches 0.
REQ-021 N > MAX_WORDS: transition to ERR at LEN_LO; no writes occur.
REQ-022 cpu_start pulses for one cycle, the cycle after entering DONE.
- It coincides with the final im_wr_en when there is no CHK state.
REQ-023 Bubbles: in_valid = 0 stalls the FSM in its current state with no side effects.
REQ-024 load_req outside DONE and ERR is ignored.
REQ-025 busy = 1 in LEN_HI through CHK; error = 1 only in ERR.

Reset
REQ-026 rst = 1 forces, on the next edge:
- state = LEN_HI, counter = 0, address = START_ADDR, checksum = 0;
- im_wr_en = 0, cpu_start = 0, error = 0, im_wr_data = 0.
REQ-027 rst mid-frame abandons the frame; no write and no cpu_start follow it.
REQ-028 rst has priority over every other input in the same cycle.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN defined:
- A running XOR covers every accepted byte from LEN_HI through the last B2.
- One extra CHK byte follows the payload.
- CHK byte equal to the running XOR: go to DONE with the cpu_start pulse.
- CHK byte not equal: go to ERR with no cpu_start.
- Words already written remain in memory.
REQ-030 Macro LOADER_CHECKSUM_EN undefined: no CHK state and no checksum register; the final B2 (or LEN_LO when N = 0) goes directly to DONE.

Structure
REQ-031 The shared CPU package holds:
- the state enum;
- INST_W = 19, PC_W = 12, BYTE_W = 8.
REQ-032 One sub-module, loader_word_asm, assembles the 3 bytes into the 19-bit word; the FSM, counter and address stay in prog_loader.

Verification
REQ-033 N = 2, bytes 00 02 05 A1 3C 07 FF 00, START_ADDR = 0 -> writes addr 0 = 0x5A13C and addr 1 = 0x7FF00; cpu_start pulses once.
REQ-034 N = 0, bytes 00 00 -> no im_wr_en; cpu_start one cycle later; with checksum enabled, CHK byte 00 is required first.
REQ-035 Random in_valid gaps over the N = 2 frame -> identical writes and cpu_start.
REQ-036 START_ADDR = 12'hFFF, N = 2 -> writes to FFF then 000.
REQ-037 rst asserted after B1 of word 0, then the N = 1 frame 00 01 00 00 2A -> a single write of 0x0002A to START_ADDR.
REQ-038 With checksum enabled, a corrupted CHK byte -> error = 1, in_ready = 0, no cpu_start; load_req -> LEN_HI.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared widths and loader FSM states
package prog_loader_pkg;

    localparam int INST_W = 19;
    localparam int PC_W   = 12;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_B0,
        S_B1,
        S_B2,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/prog_loader_word_asm.sv
// loader_word_asm: collects B0/B1 and forms the 19-bit word {B0[2:0], B1, B2} with B2 taken live
module loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              cap0_i,
    input  logic              cap1_i,
    output logic [INST_W-1:0] word_o
);

    logic [2:0]        b0_q;
    logic [BYTE_W-1:0] b1_q;

    // hold the low bits of B0 and all of B1 until B2 arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            if (cap0_i) b0_q <= data_i[2:0];
            if (cap1_i) b1_q <= data_i;
        end
    end

    assign word_o = {b0_q, b1_q, data_i};

endmodule

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader into instruction memory; LOADER_CHECKSUM_EN adds a trailing XOR check byte
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [PC_W-1:0] START_ADDR = 12'h000,
    parameter int              MAX_WORDS  = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_wr_en,
    output logic [PC_W-1:0]   im_wr_addr,
    output logic [INST_W-1:0] im_wr_data,
    output logic              cpu_start,
    output logic              busy,
    output logic              error
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN_S = S_CHK;
`else
    localparam state_t FIN_S = S_DONE;
`endif

    state_t            state_q, state_d;
    logic [3:0]        len_hi_q, len_hi_d;
    logic [PC_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              start_q, start_d;
    logic [INST_W-1:0] data_q, data_d;
    logic [PC_W-1:0]   n;
    logic [INST_W-1:0] word;
    logic              xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    assign in_ready   = state_q != S_DONE && state_q != S_ERR;
    assign busy       = in_ready;
    assign error      = state_q == S_ERR;
    assign xfer       = in_valid && in_ready;
    assign n          = {len_hi_q, in_data};
    assign im_wr_en   = wr_en_q;
    assign im_wr_addr = addr_q;
    assign im_wr_data = data_q;
    assign cpu_start  = start_q;

    loader_word_asm u_asm (
        .clk    (clk),
        .rst    (rst),
        .data_i (in_data),
        .cap0_i (xfer && state_q == S_B0),
        .cap1_i (xfer && state_q == S_B1),
        .word_o (word)
    );

    // frame parser: next state, word counter, write address and write strobe
    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q + PC_W'(wr_en_q);
        wr_en_d  = 1'b0;
        data_d   = data_q;
        case (state_q)
            S_LEN_HI: if (xfer) begin
                len_hi_d = in_data[3:0];
                state_d  = S_LEN_LO;
            end
            S_LEN_LO: if (xfer) begin
                cnt_d   = n;
                addr_d  = START_ADDR;
                state_d = 32'(n) > MAX_WORDS ? S_ERR : n == '0 ? FIN_S : S_B0;
            end
            S_B0: if (xfer) state_d = S_B1;
            S_B1: if (xfer) state_d = S_B2;
            S_B2: if (xfer) begin
                cnt_d   = cnt_q - 12'd1;
                wr_en_d = 1'b1;
                data_d  = word;
                state_d = cnt_q == 12'd1 ? FIN_S : S_B0;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (xfer) state_d = in_data == csum_q ? S_DONE : S_ERR;
`endif
            S_DONE, S_ERR: if (load_req) state_d = S_LEN_HI;
            default: state_d = S_LEN_HI;
        endcase
        start_d = state_d == S_DONE && state_q != S_DONE;
    end

`ifdef LOADER_CHECKSUM_EN
    // running XOR restarts on LEN_HI and covers every payload byte
    always_comb begin
        csum_d = csum_q;
        if (xfer && state_q != S_CHK) csum_d = state_q == S_LEN_HI ? in_data : csum_q ^ in_data;
    end
`endif

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LEN_HI;
            len_hi_q <= '0;
            cnt_q    <= '0;
            addr_q   <= START_ADDR;
            wr_en_q  <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            start_q  <= start_d;
            data_q   <= data_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // checksum register
    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader; two instances (START_ADDR 000 and FFF/MAX_WORDS 2) share stimulus
module tb_prog_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam bit WR_AT_START = 1'b0;
`else
    localparam bit WR_AT_START = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        rdy0, wr0, st0, busy0, err0;
    logic        rdy1, wr1, st1, busy1, err1;
    logic [11:0] a0, a1;
    logic [18:0] d0, d1;

    typedef struct {
        bit          wr;
        logic [11:0] a0;
        logic [11:0] a1;
        logic [18:0] d;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  fails = 0;

    always #5 clk = ~clk;

    prog_loader #(.START_ADDR(12'h000), .MAX_WORDS(4096)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .im_wr_en(wr0), .im_wr_addr(a0), .im_wr_data(d0),
        .cpu_start(st0), .busy(busy0), .error(err0)
    );

    prog_loader #(.START_ADDR(12'hFFF), .MAX_WORDS(2)) dut_hi (
        .clk(clk), .rst(rst), .load_req(load_req), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .im_wr_en(wr1), .im_wr_addr(a1), .im_wr_data(d1),
        .cpu_start(st1), .busy(busy1), .error(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [11:0] off, input logic [18:0] data);
        ev_t e;
        e.wr = 1'b1;
        e.a0 = off;
        e.a1 = 12'hFFF + off;
        e.d  = data;
        sb.push_back(e);
    endtask

    task automatic exp_start();
        ev_t e;
        e.wr = 1'b0;
        e.a0 = '0;
        e.a1 = '0;
        e.d  = '0;
        sb.push_back(e);
    endtask

    // monitor: every write or start pulse must match the next expected event
    always @(negedge clk) begin
        ev_t e;
        if (wr0 || wr1) begin
            if (sb.size() == 0) check("unexpected_write", {30'd0, wr0, wr1}, 32'd0);
            else begin
                e = sb.pop_front();
                check("event_is_write", {31'd0, e.wr}, 32'd1);
                check("wr_en_dut", {31'd0, wr0}, 32'd1);
                check("wr_en_dut_hi", {31'd0, wr1}, 32'd1);
                check("wr_addr_dut", {20'd0, a0}, {20'd0, e.a0});
                check("wr_addr_dut_hi", {20'd0, a1}, {20'd0, e.a1});
                check("wr_data_dut", {13'd0, d0}, {13'd0, e.d});
                check("wr_data_dut_hi", {13'd0, d1}, {13'd0, e.d});
            end
        end
        if (st0 || st1) begin
            if (sb.size() == 0) check("unexpected_start", {30'd0, st0, st1}, 32'd0);
            else begin
                e = sb.pop_front();
                check("event_is_start", {31'd0, e.wr}, 32'd0);
                check("start_dut", {31'd0, st0}, 32'd1);
                check("start_dut_hi", {31'd0, st1}, 32'd1);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                in_data = 8'($urandom);
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !rdy0; t++) begin
            @(posedge clk);
            #1;
        end
        check("in_ready_for_byte", {31'd0, rdy0}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bs[$], input bit gaps, input int lreq_at);
        foreach (bs[i]) begin
            load_req = (i == lreq_at);
            send_byte(bs[i], gaps);
            load_req = 1'b0;
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (bs[i]) x ^= bs[i];
            send_byte(x, gaps);
        end
`endif
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] f[$];
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {31'd0, rdy0}, 32'd1);
        check("rst_busy", {31'd0, busy0}, 32'd1);
        check("rst_error", {31'd0, err0}, 32'd0);
        check("rst_wr_en", {31'd0, wr0}, 32'd0);
        check("rst_start", {31'd0, st0}, 32'd0);
        check("rst_wr_data", {13'd0, d0}, 32'd0);
        check("rst_addr", {20'd0, a0}, 32'h000);
        check("rst_addr_hi", {20'd0, a1}, 32'hFFF);

        f = '{8'h00, 8'h02, 8'h05, 8'hA1, 8'h3C, 8'h07, 8'hFF, 8'h00};
        exp_wr(12'd0, 19'h5A13C);
        exp_wr(12'd1, 19'h7FF00);
        exp_start();
        send_frame(f, 1'b0, -1);
        check("start_after_done", {31'd0, st0}, 32'd1);
        check("final_write_vs_start", {31'd0, wr0}, {31'd0, WR_AT_START});
        @(posedge clk);
        #1;
        check("start_one_cycle", {31'd0, st0}, 32'd0);
        check("done_in_ready", {31'd0, rdy0}, 32'd0);
        check("done_busy", {31'd0, busy0}, 32'd0);
        check("done_error", {31'd0, err0}, 32'd0);
        drain();

        pulse_load();
        check("restart_in_ready", {31'd0, rdy0}, 32'd1);
        f = '{8'hA0, 8'h00};
        exp_start();
        send_frame(f, 1'b0, -1);
        check("n0_start", {31'd0, st0}, 32'd1);
        check("n0_no_write", {31'd0, wr0}, 32'd0);
        drain();

        pulse_load();
        f = '{8'h00, 8'h02, 8'h05, 8'hA1, 8'h3C, 8'h07, 8'hFF, 8'h00};
        exp_wr(12'd0, 19'h5A13C);
        exp_wr(12'd1, 19'h7FF00);
        exp_start();
        send_frame(f, 1'b1, 4);
        drain();

        pulse_load();
        f = '{8'h00, 8'h02, 8'h05, 8'hA1};
        foreach (f[i]) send_byte(f[i], 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy0}, 32'd1);
        check("midrst_addr", {20'd0, a0}, 32'h000);
        check("midrst_addr_hi", {20'd0, a1}, 32'hFFF);
        f = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h2A};
        exp_wr(12'd0, 19'h0002A);
        exp_start();
        send_frame(f, 1'b0, -1);
        drain();

        pulse_load();
        f = '{8'h00, 8'h01, 8'hFB, 8'h12, 8'h34};
        exp_wr(12'd0, 19'h31234);
`ifdef LOADER_CHECKSUM_EN
        foreach (f[i]) send_byte(f[i], 1'b0);
        send_byte(8'h23, 1'b0);
        check("badchk_error", {31'd0, err0}, 32'd1);
        check("badchk_in_ready", {31'd0, rdy0}, 32'd0);
        check("badchk_busy", {31'd0, busy0}, 32'd0);
        drain();
        check("badchk_error_held", {31'd0, err0}, 32'd1);
        pulse_load();
        check("err_restart_ready", {31'd0, rdy0}, 32'd1);
        check("err_restart_error", {31'd0, err0}, 32'd0);
`else
        exp_start();
        send_frame(f, 1'b0, -1);
        drain();
        pulse_load();
`endif

        send_byte(8'hF0, 1'b0);
        send_byte(8'h03, 1'b0);
        check("oversize_error_hi", {31'd0, err1}, 32'd1);
        check("oversize_ready_hi", {31'd0, rdy1}, 32'd0);
        check("oversize_busy_hi", {31'd0, busy1}, 32'd0);
        check("in_range_error", {31'd0, err0}, 32'd0);
        check("in_range_busy", {31'd0, busy0}, 32'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
